q_flop_pipe: RTL and testbench
==============================

Name: q_flop_pipe

Overview:
- Parametrised successor to the single-bit Q-flop: resolves a WIDTH-bit asynchronous input word into the clk domain with a four-phase req/ack handshake, as the Q-flop's resolver+ack pair does.
- Adds a stability-based resolution model with bounded wait, per-word forced-resolution flag, and a DEPTH-entry output buffer with valid/ready.
- Sits at Q-flop pipeline stage boundaries, feeding synchronous consumers.

Parameters:
- WIDTH, 8, data word width (>=1).
- DEPTH, 4, output buffer entries (power of 2, >=2).
- SETTLE, 2, consecutive matching samples needed to declare a word resolved (>=1).
- MAX_WAIT, 8, RESOLVE cycles before resolution is forced (> SETTLE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_req  in  1  four-phase request from the asynchronous producer.
- in_data  in  WIDTH  asynchronous data; must be held until in_ack rises.
- in_ack  out  1  four-phase acknowledge.
- out_data  out  WIDTH  head-of-buffer word.
- out_forced  out  1  head word was force-resolved (timeout).
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts head when out_valid is high.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ack=0, out_valid=0, out_data=0, out_forced=0; buffer emptied; shadow and counters cleared. Reset mid-handshake abandons the word (nothing written); producer must restart at in_req=0.
- FSM states: IDLE, RESOLVE, ACK_WAIT.
- IDLE: if in_req=1 and buffer not full -> shadow<=in_data, stab=0, wait=0, go RESOLVE. If full, stay in IDLE, sampling nothing.
- RESOLVE (per edge): wait<=wait+1.
  - If in_data==shadow: stab<=stab+1. If stab+1==SETTLE, write {forced=0, shadow} to buffer and go ACK_WAIT.
  - Else: shadow<=in_data, stab<=0.
  - If not settled and wait+1==MAX_WAIT: write {forced=1, shadow (value after this edge's update)} and go ACK_WAIT.
  - Settle takes priority over timeout on the same edge.
- ACK_WAIT: in_ack=1 (registered; equals state==ACK_WAIT). When in_req=0 -> IDLE, and in_ack falls the same edge.
- Latency: stable input gives SETTLE+1 edges from first edge seeing in_req=1 to in_ack/out_valid high. Worst case: MAX_WAIT+1.
- Buffer: circular, log2(DEPTH)+1-bit pointers; count in 0..DEPTH.
  - Push only on RESOLVE->ACK_WAIT transition. Pop when out_valid & out_ready.
  - Simultaneous push+pop: count unchanged.
  - Full is checked only at IDLE entry, so a push never overflows. Pop on empty is ignored.
  - Pointers wrap modulo DEPTH. out_data/out_forced are combinational from the head entry; 0 when empty.

Optional Feature:
- Macro: Q_FLOP_STATUS_EN.
- Defined: adds output forced_cnt [15:0], a saturating count of forced resolutions (holds at 16'hFFFF, reset 0), and output level [log2(DEPTH):0] equal to the buffer count.
- Undefined: neither port exists. out_forced still reported per word.

Test Plan:
- Stable word: in_data=8'hA5, in_req=1 at edge 0 -> in_ack=1 and out_valid=1 after edge 2, out_data=8'hA5, out_forced=0; in_req=0 -> in_ack=0 next edge.
- Toggling data: in_data alternates 8'h0F/8'hF0 every cycle -> forced after edge 8, out_forced=1, out_data=last sampled value; with STATUS_EN, forced_cnt=1.
- Settle-late: data changes once at edge 1 then stable -> resolved with new value after edge 3, out_forced=0.
- Fill: 4 words 8'h01..8'h04 with out_ready=0 -> 4 pushes, 5th in_req stays unacked; pop one -> 5th is accepted; drain order 01,02,03,04,05.
- Simultaneous push+pop at count=2 -> count stays 2, wrap-around order preserved over 10 words.
- Reset mid-RESOLVE (rst=0 at edge 1, async) -> in_ack=0 and out_valid=0 immediately; no word in buffer after release.

Source files
------------

// File: rtl/q_flop_pipe.sv
// rtl/q_flop_pipe.sv - multi-bit Q-flop resolver with four-phase handshake and output buffer
//
// Purpose:
//   Resolves a WIDTH-bit word from an asynchronous four-phase producer into the
//   clk domain. A word is accepted when the sampled value stays unchanged for
//   SETTLE consecutive edges, or force-resolved after MAX_WAIT edges. Resolved
//   words land in a DEPTH-entry circular buffer drained with valid/ready.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   in_req      in   four-phase request from the producer
//   in_data     in   producer data word, held until in_ack rises
//   in_ack      out  four-phase acknowledge (high while in ACK_WAIT)
//   out_data    out  head-of-buffer word, 0 when empty
//   out_forced  out  head word was force-resolved, 0 when empty
//   out_valid   out  buffer non-empty
//   out_ready   in   consumer takes the head word when out_valid is high
//
// Optional feature (macro Q_FLOP_STATUS_EN):
//   forced_cnt  out  saturating count of forced resolutions
//   level       out  current buffer occupancy

module q_flop_pipe #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SETTLE   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_req,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ack,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_forced,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef Q_FLOP_STATUS_EN
    ,
    output logic [15:0]              forced_cnt,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESOLVE  = 2'd1;
    localparam logic [1:0] ST_ACK_WAIT = 2'd2;

    // Counter values that mark the final RESOLVE edge for each condition:
    // the edge where the incremented counter would reach its limit.
    localparam logic [SW-1:0] STAB_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Resolver state
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [WW-1:0]    wait_q, wait_d;

    // ------------------------------------------------------------------
    // Buffer state
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             settle_hit;
    logic [WIDTH:0]   push_word;
    logic [WIDTH:0]   head_word;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_C);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        stab_d     = stab_q;
        wait_d     = wait_q;
        push       = 1'b0;
        push_word  = '0;
        settle_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Occupancy is only checked here, so once a word is in
                // RESOLVE there is always a slot reserved for it.
                if (in_req && !full) begin
                    shadow_d = in_data;
                    stab_d   = '0;
                    wait_d   = '0;
                    state_d  = ST_RESOLVE;
                end
            end

            ST_RESOLVE: begin
                wait_d = wait_q + WAIT_ONE;
                if (in_data == shadow_q) begin
                    stab_d = stab_q + STAB_ONE;
                    if (stab_q == STAB_LAST) begin
                        settle_hit = 1'b1;
                    end
                end else begin
                    shadow_d = in_data;
                    stab_d   = '0;
                end

                // Settling wins over timeout when both land on one edge.
                if (settle_hit) begin
                    push      = 1'b1;
                    push_word = {1'b0, shadow_q};
                    state_d   = ST_ACK_WAIT;
                end else if (wait_q == WAIT_LAST) begin
                    // Forced word carries the most recent sample.
                    push      = 1'b1;
                    push_word = {1'b1, shadow_d};
                    state_d   = ST_ACK_WAIT;
                end
            end

            ST_ACK_WAIT: begin
                if (!in_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            stab_q   <= '0;
            wait_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            stab_q   <= stab_d;
            wait_q   <= wait_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head_word  = mem_q[rd_ptr_q[PW-1:0]];
    assign in_ack     = (state_q == ST_ACK_WAIT);
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : head_word[WIDTH-1:0];
    assign out_forced = empty ? 1'b0 : head_word[WIDTH];

`ifdef Q_FLOP_STATUS_EN
    logic [15:0] forced_cnt_q, forced_cnt_d;

    always_comb begin
        forced_cnt_d = forced_cnt_q;
        if (push && push_word[WIDTH] && (forced_cnt_q != 16'hFFFF)) begin
            forced_cnt_d = forced_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            forced_cnt_q <= '0;
        end else begin
            forced_cnt_q <= forced_cnt_d;
        end
    end

    assign forced_cnt = forced_cnt_q;
    assign level      = count;
`endif

endmodule

// File: tb/tb_q_flop_pipe.sv
// tb/tb_q_flop_pipe.sv - scoreboard testbench for q_flop_pipe

module tb_q_flop_pipe;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int SETTLE   = 2;
    localparam int MAX_WAIT = 8;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_req;
    logic [WIDTH-1:0] in_data;
    logic             in_ack;
    logic [WIDTH-1:0] out_data;
    logic             out_forced;
    logic             out_valid;
    logic             out_ready;
`ifdef Q_FLOP_STATUS_EN
    logic [15:0]      forced_cnt;
    logic [LW-1:0]    level;
`endif

    q_flop_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .SETTLE   (SETTLE),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .out_data   (out_data),
        .out_forced (out_forced),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef Q_FLOP_STATUS_EN
        ,
        .forced_cnt (forced_cnt),
        .level      (level)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;           // 0: never ready, 1: always ready, 2: random
    int exp_forced_total = 0;
    logic [WIDTH:0]   sb [$];     // expected {forced, data} in push order
    logic [WIDTH-1:0] seq [0:MAX_WAIT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: drives out_ready just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a transfer seen here completes on the next rising edge.
    always @(negedge clk) begin
        logic [WIDTH:0] exp_w;
        if (rst) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %0h expected none", out_data);
                    end else begin
                        exp_w = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(exp_w[WIDTH-1:0]));
                        check("out_forced", 32'(out_forced), 32'(exp_w[WIDTH]));
                    end
                end
            end else begin
                check("empty_outputs", 32'({out_forced, out_data}), 32'd0);
            end
        end
    end

    // Reference: a word resolves at the first edge e whose sample equals the
    // SETTLE samples before it; otherwise it is forced at edge MAX_WAIT with
    // that edge's sample. Sample k is what the DUT sees at edge k after accept.
    task automatic run_word();
        int   j;
        int   guard;
        logic forced;
        logic same;
        j = MAX_WAIT;
        forced = 1'b1;
        for (int e = SETTLE; e <= MAX_WAIT; e++) begin
            same = 1'b1;
            for (int i = e - SETTLE; i < e; i++) begin
                if (seq[i] != seq[e]) same = 1'b0;
            end
            if (same && forced) begin
                j = e;
                forced = 1'b0;
            end
        end
        guard = 0;
        while (sb.size() >= DEPTH && guard < 200) begin
            @(posedge clk); #2;
            guard++;
        end
        check("room_wait_bound", 32'(guard >= 200), 32'd0);
        sb.push_back({forced, seq[j]});
        if (forced) exp_forced_total++;
        in_data = seq[0];
        in_req  = 1'b1;
        for (int k = 0; k <= MAX_WAIT; k++) begin
            @(posedge clk); #2;
            check("in_ack_latency", 32'(in_ack), 32'(k >= j));
            if (k == j) check("valid_on_push", 32'(out_valid), 32'd1);
            if (k < MAX_WAIT) in_data = seq[k + 1];
        end
        in_req = 1'b0;
        @(posedge clk); #2;
        check("ack_fall", 32'(in_ack), 32'd0);
`ifdef Q_FLOP_STATUS_EN
        check("level", 32'(level), 32'(sb.size()));
`endif
    endtask

    task automatic fill_seq(input logic [WIDTH-1:0] v);
        for (int i = 0; i <= MAX_WAIT; i++) seq[i] = v;
    endtask

    task automatic drain();
        int guard;
        ready_mode = 1;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        check("drain_bound", 32'(guard >= 100), 32'd0);
        @(posedge clk); #2;
        check("drained_valid", 32'(out_valid), 32'd0);
        ready_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int mode;
        int c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b0; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack", 32'(in_ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_forced", 32'(out_forced), 32'd0);
`ifdef Q_FLOP_STATUS_EN
        check("rst_forced_cnt", 32'(forced_cnt), 32'd0);
        check("rst_level", 32'(level), 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #2;

        // Stable word
        fill_seq(8'hA5);
        run_word();
        drain();

        // Alternating data forces resolution
        for (int i = 0; i <= MAX_WAIT; i++) seq[i] = (i % 2 != 0) ? 8'hF0 : 8'h0F;
        run_word();
        drain();
`ifdef Q_FLOP_STATUS_EN
        check("forced_cnt_one", 32'(forced_cnt), 32'd1);
`endif

        // Data changes once, then settles
        fill_seq(8'h22);
        seq[0] = 8'h11;
        run_word();
        drain();

        // Fill the buffer, stall the fifth word, release one slot
        for (int v = 1; v <= DEPTH; v++) begin
            fill_seq(8'(v));
            run_word();
        end
        sb.push_back({1'b0, 8'h05});
        in_data = 8'h05;
        in_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("full_stall_ack", 32'(in_ack), 32'd0);
        end
        ready_mode = 1;
        @(posedge clk); #2;
        ready_mode = 0;
        guard = 0;
        while (!in_ack && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        check("accept_after_pop", 32'(in_ack), 32'd1);
        in_req = 1'b0;
        @(posedge clk); #2;
        check("ack_fall_fill", 32'(in_ack), 32'd0);
        drain();

        // Asynchronous reset while a word is resolving
        fill_seq(8'h3C);
        run_word();
        in_data = 8'h77;
        in_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_ack", 32'(in_ack), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        sb.delete();
        exp_forced_total = 0;
        in_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_ack", 32'(in_ack), 32'd0);
        end

        // Random consumer with steady words: push and pop overlap, pointers wrap
        ready_mode = 2;
        for (int w = 0; w < 10; w++) begin
            fill_seq(8'($urandom));
            run_word();
        end

        // Random producer patterns
        for (int w = 0; w < 30; w++) begin
            mode = $urandom_range(0, 3);
            a = 8'($urandom);
            b = a ^ 8'($urandom_range(1, 255));
            c = $urandom_range(1, MAX_WAIT);
            for (int i = 0; i <= MAX_WAIT; i++) begin
                case (mode)
                    0:       seq[i] = a;
                    1:       seq[i] = (i < c) ? a : b;
                    2:       seq[i] = ($urandom_range(0, 2) == 0) ? b : a;
                    default: seq[i] = 8'($urandom);
                endcase
            end
            run_word();
        end
        drain();
`ifdef Q_FLOP_STATUS_EN
        check("forced_cnt_total", 32'(forced_cnt), 32'(exp_forced_total));
        check("level_empty", 32'(level), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
